// File: rtl/local_mem_weight_param.sv
// -----------------------------------------------------------------------------
// local_mem_weight_param
//
// Local weight store. Incoming weight words are packed, lane by lane, into
// rows of LANES*DATA_W bits. The packing width L is taken from cfg_lanes at
// the start of each row. Two independent registered read ports return whole
// rows with one cycle of latency.
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst           synchronous active-high reset
//   cfg_lanes     active lanes per row for this store pass (0 -> 1, >LANES -> LANES)
//   cfg_last_row  final row index of the store pass
//   wr_clear      restart the store pass (pointers to row 0 / lane 0)
//   wr_valid      wr_data valid this cycle
//   wr_data       weight word to pack
//   wr_ready      word is accepted this cycle (low during rst or wr_clear)
//   wr_row        current write row pointer
//   wr_lane       current write lane pointer
//   store_done    one-cycle pulse after the last word of the pass is written
//   rd_en_x       read request on port A / B
//   rd_addr_x     row to read on port A / B
//   rd_data_x     registered row data, lane k at [k*DATA_W +: DATA_W]
//   rd_valid_x    rd_data_x updated by a read in the previous cycle
//   rd_err_x      last accepted read address was out of range
// -----------------------------------------------------------------------------
module local_mem_weight_param #(
   parameter int DATA_W = 16,
   parameter int LANES  = 8,
   parameter int DEPTH  = 80,
   parameter int ADDR_W = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [3:0]                cfg_lanes,
   input  logic [ADDR_W-1:0]         cfg_last_row,
   input  logic                      wr_clear,
   input  logic                      wr_valid,
   input  logic [DATA_W-1:0]         wr_data,
   output logic                      wr_ready,
   output logic [ADDR_W-1:0]         wr_row,
   output logic [3:0]                wr_lane,
   output logic                      store_done,
   input  logic                      rd_en_a,
   input  logic [ADDR_W-1:0]         rd_addr_a,
   output logic [LANES*DATA_W-1:0]   rd_data_a,
   output logic                      rd_valid_a,
   output logic                      rd_err_a,
   input  logic                      rd_en_b,
   input  logic [ADDR_W-1:0]         rd_addr_b,
   output logic [LANES*DATA_W-1:0]   rd_data_b,
   output logic                      rd_valid_b,
   output logic                      rd_err_b
);

   localparam int                ROW_W      = LANES * DATA_W;
   localparam logic [3:0]        LANES_C    = 4'(LANES);
   localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ROW_C = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ROW_ONE_C  = ADDR_W'(1);

   logic [ROW_W-1:0]  mem_r [0:DEPTH-1];

   logic [ADDR_W-1:0] wr_row_r;
   logic [3:0]        wr_lane_r;
   logic              store_done_r;
   logic [3:0]        lanes_r;        // L latched at lane 0 of the current row

   logic              accept_s;
   logic [3:0]        cfg_sat_s;
   logic [3:0]        cur_lanes_s;
   logic              row_end_s;
   logic              pass_end_s;
   logic              oob_a_s;
   logic              oob_b_s;

   logic [ROW_W-1:0]  rd_data_a_r;
   logic [ROW_W-1:0]  rd_data_b_r;
   logic              rd_valid_a_r;
   logic              rd_valid_b_r;
   logic              rd_err_a_r;
   logic              rd_err_b_r;

   // wr_clear and reset both block acceptance in the same cycle.
   assign wr_ready   = !rst && !wr_clear;
   assign accept_s   = wr_valid && wr_ready;

   assign wr_row     = wr_row_r;
   assign wr_lane    = wr_lane_r;
   assign store_done = store_done_r;
   assign rd_data_a  = rd_data_a_r;
   assign rd_data_b  = rd_data_b_r;
   assign rd_valid_a = rd_valid_a_r;
   assign rd_valid_b = rd_valid_b_r;
   assign rd_err_a   = rd_err_a_r;
   assign rd_err_b   = rd_err_b_r;

   // Lane-count saturation and end-of-row / end-of-pass detection.
   always_comb begin
      cfg_sat_s = cfg_lanes;
      if (cfg_lanes == 4'd0) begin
         cfg_sat_s = 4'd1;
      end else if (cfg_lanes > LANES_C) begin
         cfg_sat_s = LANES_C;
      end else begin
         cfg_sat_s = cfg_lanes;
      end
      // A word at lane 0 opens a new row, so it already obeys the new L.
      if (wr_lane_r == 4'd0) begin
         cur_lanes_s = cfg_sat_s;
      end else begin
         cur_lanes_s = lanes_r;
      end
      row_end_s  = (wr_lane_r == (cur_lanes_s - 4'd1));
      pass_end_s = row_end_s && ((wr_row_r == cfg_last_row) || (wr_row_r == LAST_ROW_C));
      oob_a_s    = ({1'b0, rd_addr_a} >= DEPTH_C);
      oob_b_s    = ({1'b0, rd_addr_b} >= DEPTH_C);
   end

   // Write pointers, latched lane count and store_done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_row_r     <= {ADDR_W{1'b0}};
         wr_lane_r    <= 4'd0;
         store_done_r <= 1'b0;
         lanes_r      <= 4'd1;
      end else if (wr_clear) begin
         wr_row_r     <= {ADDR_W{1'b0}};
         wr_lane_r    <= 4'd0;
         store_done_r <= 1'b0;
      end else if (accept_s) begin
         store_done_r <= pass_end_s;
         if (wr_lane_r == 4'd0) begin
            lanes_r <= cfg_sat_s;
         end
         if (row_end_s) begin
            wr_lane_r <= 4'd0;
            wr_row_r  <= pass_end_s ? {ADDR_W{1'b0}} : (wr_row_r + ROW_ONE_C);
         end else begin
            wr_lane_r <= wr_lane_r + 4'd1;
         end
      end else begin
         store_done_r <= 1'b0;
      end
   end

   // Storage write: lane 0 rewrites the whole row with upper lanes zeroed.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         if (wr_lane_r == 4'd0) begin
            mem_r[wr_row_r] <= ROW_W'(wr_data);
         end else begin
            for (int k = 1; k < LANES; k++) begin
               if (wr_lane_r == 4'(k)) begin
                  mem_r[wr_row_r][k*DATA_W +: DATA_W] <= wr_data;
               end
            end
         end
      end
   end

   // Read port A; rd_data/rd_err hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_a_r  <= {ROW_W{1'b0}};
         rd_valid_a_r <= 1'b0;
         rd_err_a_r   <= 1'b0;
      end else if (rd_en_a) begin
         rd_valid_a_r <= 1'b1;
         if (oob_a_s) begin
            rd_data_a_r <= {ROW_W{1'b0}};
            rd_err_a_r  <= 1'b1;
         end else begin
            rd_data_a_r <= mem_r[rd_addr_a];
            rd_err_a_r  <= 1'b0;
         end
      end else begin
         rd_valid_a_r <= 1'b0;
      end
   end

   // Read port B; independent copy of port A.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_b_r  <= {ROW_W{1'b0}};
         rd_valid_b_r <= 1'b0;
         rd_err_b_r   <= 1'b0;
      end else if (rd_en_b) begin
         rd_valid_b_r <= 1'b1;
         if (oob_b_s) begin
            rd_data_b_r <= {ROW_W{1'b0}};
            rd_err_b_r  <= 1'b1;
         end else begin
            rd_data_b_r <= mem_r[rd_addr_b];
            rd_err_b_r  <= 1'b0;
         end
      end else begin
         rd_valid_b_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_local_mem_weight_param.sv
// -----------------------------------------------------------------------------
// tb_local_mem_weight_param
//
// Directed bench for local_mem_weight_param with default parameters. Inputs
// are driven 1 ns after the rising edge, outputs are checked 1 ns after the
// following rising edge.
// -----------------------------------------------------------------------------
module tb_local_mem_weight_param;

   localparam int DATA_W = 16;
   localparam int LANES  = 8;
   localparam int DEPTH  = 80;
   localparam int ADDR_W = 7;
   localparam int ROW_W  = LANES * DATA_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        cfg_lanes;
   logic [ADDR_W-1:0] cfg_last_row;
   logic              wr_clear;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_row;
   logic [3:0]        wr_lane;
   logic              store_done;
   logic              rd_en_a;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ROW_W-1:0]  rd_data_a;
   logic              rd_valid_a;
   logic              rd_err_a;
   logic              rd_en_b;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [ROW_W-1:0]  rd_data_b;
   logic              rd_valid_b;
   logic              rd_err_b;

   int checks   = 0;
   int failures = 0;

   logic [ROW_W-1:0] row0_exp;
   logic [ROW_W-1:0] exp_row;

   local_mem_weight_param #(
      .DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_lanes(cfg_lanes), .cfg_last_row(cfg_last_row),
      .wr_clear(wr_clear), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .wr_row(wr_row), .wr_lane(wr_lane),
      .store_done(store_done),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_valid_a(rd_valid_a), .rd_err_a(rd_err_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .rd_valid_b(rd_valid_b), .rd_err_b(rd_err_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DATA_W-1:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic clear_pass();
      wr_clear = 1'b1;
      tick();
      wr_clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (wr_row !== 7'd0) begin failures++; $display("FAIL reset_wr_row got=%0h exp=0", wr_row); end
      checks++; if (wr_lane !== 4'd0) begin failures++; $display("FAIL reset_wr_lane got=%0h exp=0", wr_lane); end
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%0b exp=0", wr_ready); end
      checks++; if (store_done !== 1'b0) begin failures++; $display("FAIL reset_store_done got=%0b exp=0", store_done); end
      checks++; if ({rd_valid_a, rd_valid_b, rd_err_a, rd_err_b} !== 4'b0000) begin failures++; $display("FAIL reset_rd_flags got=%b exp=0000", {rd_valid_a, rd_valid_b, rd_err_a, rd_err_b}); end
      checks++; if ({rd_data_a, rd_data_b} !== {(2*ROW_W){1'b0}}) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", {rd_data_a, rd_data_b}); end
      rst = 1'b0;
      #1;
      checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%0b exp=1", wr_ready); end
   endtask

   // Three lanes per row, two rows: words 1..6.
   task automatic test_pack();
      cfg_lanes    = 4'd3;
      cfg_last_row = 7'd1;
      for (int i = 1; i <= 6; i++) begin
         write_word(16'(i));
         checks++; if (store_done !== ((i == 6) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL pack_store_done word=%0d got=%0b exp=%0b", i, store_done, (i == 6)); end
         checks++; if ({wr_row, wr_lane} !== {7'((i / 3) % 2), 4'(i % 3)}) begin failures++; $display("FAIL pack_ptr word=%0d got=%0d/%0d exp=%0d/%0d", i, wr_row, wr_lane, (i / 3) % 2, i % 3); end
      end
      tick();
      checks++; if (store_done !== 1'b0) begin failures++; $display("FAIL pack_done_pulse got=%0b exp=0", store_done); end
      rd_en_a = 1'b1; rd_addr_a = 7'd0;
      rd_en_b = 1'b1; rd_addr_b = 7'd1;
      tick();
      rd_en_a = 1'b0; rd_en_b = 1'b0;
      checks++; if (rd_data_a !== {80'd0, 16'd3, 16'd2, 16'd1}) begin failures++; $display("FAIL pack_row0 got=%h exp=%h", rd_data_a, {80'd0, 16'd3, 16'd2, 16'd1}); end
      checks++; if (rd_data_b !== {80'd0, 16'd6, 16'd5, 16'd4}) begin failures++; $display("FAIL pack_row1 got=%h exp=%h", rd_data_b, {80'd0, 16'd6, 16'd5, 16'd4}); end
   endtask

   // Full-width row, dual-port read of the same row.
   task automatic test_full_row();
      cfg_lanes    = 4'd8;
      cfg_last_row = 7'd0;
      row0_exp     = {ROW_W{1'b0}};
      for (int i = 1; i <= 8; i++) begin
         write_word(16'(i * 17));
         row0_exp[(i-1)*DATA_W +: DATA_W] = 16'(i * 17);
      end
      checks++; if ({store_done, wr_row, wr_lane} !== {1'b1, 7'd0, 4'd0}) begin failures++; $display("FAIL full_done_ptr got=%0b/%0d/%0d exp=1/0/0", store_done, wr_row, wr_lane); end
      rd_en_a = 1'b1; rd_addr_a = 7'd0;
      rd_en_b = 1'b1; rd_addr_b = 7'd0;
      tick();
      rd_en_a = 1'b0; rd_en_b = 1'b0;
      checks++; if (rd_data_a !== row0_exp) begin failures++; $display("FAIL full_row_a got=%h exp=%h", rd_data_a, row0_exp); end
      checks++; if (rd_data_b !== row0_exp) begin failures++; $display("FAIL full_row_b got=%h exp=%h", rd_data_b, row0_exp); end
      checks++; if ({rd_valid_a, rd_valid_b} !== 2'b11) begin failures++; $display("FAIL full_valid got=%b exp=11", {rd_valid_a, rd_valid_b}); end
      tick();
      checks++; if (rd_valid_a !== 1'b0) begin failures++; $display("FAIL idle_valid got=%0b exp=0", rd_valid_a); end
      checks++; if (rd_data_a !== row0_exp) begin failures++; $display("FAIL idle_hold got=%h exp=%h", rd_data_a, row0_exp); end
   endtask

   task automatic test_out_of_range();
      rd_en_a = 1'b1; rd_addr_a = 7'd80;
      tick();
      checks++; if ({rd_valid_a, rd_err_a} !== 2'b11) begin failures++; $display("FAIL oob_flags got=%b exp=11", {rd_valid_a, rd_err_a}); end
      checks++; if (rd_data_a !== {ROW_W{1'b0}}) begin failures++; $display("FAIL oob_data got=%h exp=0", rd_data_a); end
      rd_addr_a = 7'd0;
      tick();
      rd_en_a = 1'b0;
      checks++; if ({rd_valid_a, rd_err_a} !== 2'b10) begin failures++; $display("FAIL inrange_flags got=%b exp=10", {rd_valid_a, rd_err_a}); end
      checks++; if (rd_data_a !== row0_exp) begin failures++; $display("FAIL inrange_data got=%h exp=%h", rd_data_a, row0_exp); end
   endtask

   // wr_clear with a valid word at lane 5 drops the word.
   task automatic test_clear();
      cfg_lanes    = 4'd8;
      cfg_last_row = 7'd5;
      exp_row      = {ROW_W{1'b0}};
      for (int i = 0; i < 5; i++) begin
         write_word(16'(16'hA000 + i));
         exp_row[i*DATA_W +: DATA_W] = 16'(16'hA000 + i);
      end
      checks++; if (wr_lane !== 4'd5) begin failures++; $display("FAIL clear_pre_lane got=%0d exp=5", wr_lane); end
      wr_valid = 1'b1; wr_data = 16'hBEEF; wr_clear = 1'b1;
      #1;
      checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL clear_ready got=%0b exp=0", wr_ready); end
      tick();
      wr_valid = 1'b0; wr_clear = 1'b0;
      checks++; if ({store_done, wr_row, wr_lane} !== {1'b0, 7'd0, 4'd0}) begin failures++; $display("FAIL clear_ptr got=%0b/%0d/%0d exp=0/0/0", store_done, wr_row, wr_lane); end
      rd_en_a = 1'b1; rd_addr_a = 7'd0;
      tick();
      rd_en_a = 1'b0;
      checks++; if (rd_data_a !== exp_row) begin failures++; $display("FAIL clear_nowrite got=%h exp=%h", rd_data_a, exp_row); end
   endtask

   // Read-before-write on row 2 through port B.
   task automatic test_read_before_write();
      cfg_lanes    = 4'd8;
      cfg_last_row = 7'd5;
      exp_row      = {ROW_W{1'b0}};
      for (int i = 0; i < 24; i++) begin
         write_word(16'(16'h1000 + i));
         if (i >= 16) exp_row[(i-16)*DATA_W +: DATA_W] = 16'(16'h1000 + i);
      end
      clear_pass();
      cfg_lanes = 4'd1;
      write_word(16'h0100);
      write_word(16'h0101);
      checks++; if ({wr_row, wr_lane} !== {7'd2, 4'd0}) begin failures++; $display("FAIL rbw_ptr got=%0d/%0d exp=2/0", wr_row, wr_lane); end
      rd_en_b = 1'b1; rd_addr_b = 7'd2;
      write_word(16'h5A5A);
      checks++; if (rd_data_b !== exp_row) begin failures++; $display("FAIL rbw_old got=%h exp=%h", rd_data_b, exp_row); end
      tick();
      rd_en_b = 1'b0;
      checks++; if (rd_data_b !== 128'h5A5A) begin failures++; $display("FAIL rbw_new got=%h exp=%h", rd_data_b, 128'h5A5A); end
   endtask

   // Reset in the middle of a row, with reads in flight.
   task automatic test_reset_mid_row();
      clear_pass();
      cfg_lanes = 4'd8;
      rd_en_a = 1'b1; rd_addr_a = 7'd1;
      rd_en_b = 1'b1; rd_addr_b = 7'd90;
      for (int i = 0; i < 4; i++) write_word(16'(16'hC000 + i));
      checks++; if ({wr_lane, rd_err_b, rd_valid_a} !== {4'd4, 1'b1, 1'b1}) begin failures++; $display("FAIL mid_pre got=%0d/%0b/%0b exp=4/1/1", wr_lane, rd_err_b, rd_valid_a); end
      checks++; if (rd_data_a !== 128'h0101) begin failures++; $display("FAIL mid_pre_data got=%h exp=%h", rd_data_a, 128'h0101); end
      rst = 1'b1;
      tick();
      checks++; if ({wr_row, wr_lane, store_done, wr_ready} !== {7'd0, 4'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL mid_rst_wr got=%0d/%0d/%0b/%0b exp=0/0/0/0", wr_row, wr_lane, store_done, wr_ready); end
      checks++; if ({rd_valid_a, rd_valid_b, rd_err_a, rd_err_b} !== 4'b0000) begin failures++; $display("FAIL mid_rst_rd got=%b exp=0000", {rd_valid_a, rd_valid_b, rd_err_a, rd_err_b}); end
      checks++; if ({rd_data_a, rd_data_b} !== {(2*ROW_W){1'b0}}) begin failures++; $display("FAIL mid_rst_data got=%h exp=0", {rd_data_a, rd_data_b}); end
      rst = 1'b0;
      rd_en_a = 1'b0; rd_en_b = 1'b0;
      cfg_lanes = 4'd2;
      write_word(16'h7777);
      checks++; if ({wr_row, wr_lane} !== {7'd0, 4'd1}) begin failures++; $display("FAIL mid_after_ptr got=%0d/%0d exp=0/1", wr_row, wr_lane); end
      rd_en_a = 1'b1; rd_addr_a = 7'd0;
      tick();
      rd_en_a = 1'b0;
      checks++; if (rd_data_a !== 128'h7777) begin failures++; $display("FAIL mid_after_row got=%h exp=%h", rd_data_a, 128'h7777); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      cfg_lanes    = 4'd1;
      cfg_last_row = 7'd0;
      wr_clear     = 1'b0;
      wr_valid     = 1'b0;
      wr_data      = 16'd0;
      rd_en_a      = 1'b0;
      rd_addr_a    = 7'd0;
      rd_en_b      = 1'b0;
      rd_addr_b    = 7'd0;
      row0_exp     = {ROW_W{1'b0}};
      exp_row      = {ROW_W{1'b0}};
      test_reset();
      test_pack();
      test_full_row();
      test_out_of_range();
      test_clear();
      test_read_before_write();
      test_reset_mid_row();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
